// File: rtl/mems_spi_pkg.sv
// Shared definitions for the MEMS-driver DAC path: frame width, FSM
// encoding and the DAC command prefixes used by the ROM and sequencer.
package mems_spi_pkg;

   localparam int DAC_WORD_WIDTH = 24;

   // FSM encoding, kept as plain constants so other blocks can decode it
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      GAP   = ST_GAP
   } spi_state_e;

   // Command prefix = upper byte of the 24-bit word:
   // [23:22] don't care, [21:19] command, [18:16] channel address
   localparam logic [7:0] DAC_CMD_SW_RESET   = 8'h28;
   localparam logic [7:0] DAC_CMD_LDAC_SETUP = 8'h30;
   localparam logic [7:0] DAC_CMD_WRUP_A     = 8'h18;
   localparam logic [7:0] DAC_CMD_WRUP_B     = 8'h19;
   localparam logic [7:0] DAC_CMD_WRUP_C     = 8'h1A;
   localparam logic [7:0] DAC_CMD_WRUP_D     = 8'h1B;

   // Assemble a full DAC word from a command prefix and a 16-bit payload
   function automatic logic [DAC_WORD_WIDTH-1:0] dac_word(input logic [7:0]  prefix,
                                                         input logic [15:0] val);
      return {prefix, val};
   endfunction

   // Write-and-update prefix for channel 0..3 (A..D)
   function automatic logic [7:0] dac_wrup_prefix(input logic [1:0] ch);
      return DAC_CMD_WRUP_A | {6'd0, ch};
   endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Half-period timer for the SPI clock: a CLK_DIV down-counter that emits
// a one-cycle tick each time a half period of SCLK has elapsed.
module spi_phase_timer #(
   parameter int CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,      // synchronous, active low
   input  logic restart_i,  // align the first half period to frame start
   input  logic en_i,
   output logic tick_o
);

   localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   // Next count: reload on restart or on terminal count, else count down
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = RELOAD;
      end else if (en_i) begin
         cnt_d = (cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;
      end
   end

   // Tick on terminal count; a restart in the same cycle takes priority
   assign tick_o = en_i && !restart_i && (cnt_q == 8'd0);

   // Counter register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dac_spi_master.sv
// SPI master for the four-channel MEMS-driver DAC. Accepts one word per
// start/busy handshake, shifts it out MSB first on mosi (changing on SCLK
// rise), captures miso on SCLK fall, then holds sync_n high for a gap.
module dac_spi_master
   import mems_spi_pkg::*;
#(
   parameter int WIDTH     = DAC_WORD_WIDTH,
   parameter int CLK_DIV   = 2,
   parameter int SYNC_HIGH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,      // synchronous, active low
   input  logic             start_i,
   input  logic [WIDTH-1:0] data_in_i,
   output logic             busy_o,
   output logic             new_data_o,
   output logic [WIDTH-1:0] data_out_o,
   output logic             sclk_o,
   output logic             mosi_o,
   input  logic             miso_i,
   output logic             sync_n_o
);

   localparam int         BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);
   // GAP counts down to zero; the new_data cycle is the first gap cycle
   localparam logic [7:0] GAP_LOAD = 8'(SYNC_HIGH - 1);

   spi_state_e       state_q, state_d;
   logic             busy_q, busy_d;
   logic             new_data_q, new_data_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             sync_n_q, sync_n_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [7:0]       gap_q, gap_d;

   logic accept;
   logic tick;

   // Start is only honoured from IDLE, which is exactly when busy is low
   assign accept = (state_q == IDLE) && start_i;

   spi_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .restart_i (accept),
      .en_i      (state_q == SHIFT),
      .tick_o    (tick)
   );

   // Next-state and output logic for the frame FSM
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      new_data_d = 1'b0;
      data_out_d = data_out_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      sync_n_d   = sync_n_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      bit_d      = bit_q;
      gap_d      = gap_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               // MSB goes out immediately; the first high phase is the
               // sync_n-to-SCLK-fall setup time
               state_d  = SHIFT;
               busy_d   = 1'b1;
               sync_n_d = 1'b0;
               sclk_d   = 1'b1;
               mosi_d   = data_in_i[WIDTH-1];
               tx_d     = {data_in_i[WIDTH-2:0], 1'b0};
               rx_d     = '0;
               bit_d    = BIT_TOP;
            end
         end

         SHIFT: begin
            if (tick) begin
               if (sclk_q) begin
                  // Falling edge: DAC samples mosi, we sample miso
                  sclk_d = 1'b0;
                  rx_d   = {rx_q[WIDTH-2:0], miso_i};
               end else if (bit_q == '0) begin
                  // Low phase of the last bit done: close the frame
                  state_d    = GAP;
                  sclk_d     = 1'b1;
                  sync_n_d   = 1'b1;
                  mosi_d     = 1'b0;
                  new_data_d = 1'b1;
                  data_out_d = rx_q;
                  gap_d      = GAP_LOAD;
               end else begin
                  // Rising edge: present the next bit
                  sclk_d = 1'b1;
                  mosi_d = tx_q[WIDTH-1];
                  tx_d   = {tx_q[WIDTH-2:0], 1'b0};
                  bit_d  = bit_q - 1'b1;
               end
            end
         end

         GAP: begin
            if (gap_q == 8'd0) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end

         default: begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sclk_d   = 1'b1;
            mosi_d   = 1'b0;
            sync_n_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in flight
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         new_data_q <= 1'b0;
         data_out_q <= '0;
         sclk_q     <= 1'b1;
         mosi_q     <= 1'b0;
         sync_n_q   <= 1'b1;
         tx_q       <= '0;
         rx_q       <= '0;
         bit_q      <= '0;
         gap_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         new_data_q <= new_data_d;
         data_out_q <= data_out_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         sync_n_q   <= sync_n_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         bit_q      <= bit_d;
         gap_q      <= gap_d;
      end
   end

   assign busy_o     = busy_q;
   assign new_data_o = new_data_q;
   assign data_out_o = data_out_q;
   assign sclk_o     = sclk_q;
   assign mosi_o     = mosi_q;
   assign sync_n_o   = sync_n_q;

endmodule
